// File: rtl/mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access sizes, grant owner and
// the size-to-byte-lane mask helper.
package mem_arbiter_pkg;

    localparam int dw = 64;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [1:0] {NONE, GNT_IF, GNT_D} grant_e;

    function automatic logic [7:0] size_to_mask(size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the fetch side was refused; any
// cycle without a refusal clears it.
module starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic sat
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (inc) begin
            cnt_d = (cnt_q == CNT_W'(LIMIT)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter: load/store side has priority, fetch side
// is guaranteed a grant after STARVE_LIMIT consecutive refusals.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [15:0]   if_addr,
    input  logic          if_flush,
    output logic          if_resp_valid,
    output logic [dw-1:0] if_resp_data,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [15:0]   d_addr,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [dw-1:0] d_wdata,
    output logic          d_resp_valid,
    output logic [dw-1:0] d_resp_data,
    output logic [7:0]    mem_w_mask,
    output logic [15:0]   mem_address,
    output logic [dw-1:0] mem_write_data,
    input  logic [dw-1:0] mem_read_data
);

    logic          starve_sat;
    logic          starve_inc;
    logic          override;
    logic          grant_if;
    logic          grant_d;
    grant_e        last_grant_q;
    grant_e        last_grant_d;
    logic [dw-1:0] if_resp_data_q;
    logic [dw-1:0] if_resp_data_d;
    logic [dw-1:0] d_resp_data_q;
    logic [dw-1:0] d_resp_data_d;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .sat (starve_sat)
    );

    always_comb begin
        override   = starve_sat && if_req_valid && !if_flush;
        grant_if   = !rst && if_req_valid && !if_flush && (!d_req_valid || override);
        grant_d    = !rst && d_req_valid && !grant_if;
        starve_inc = if_req_valid && !grant_if && !if_flush;

        mem_address    = '0;
        mem_w_mask     = '0;
        mem_write_data = '0;
        if (grant_if) begin
            mem_address = if_addr;
        end else if (grant_d) begin
            mem_address    = d_addr;
            mem_write_data = d_wdata;
            if (d_we) begin
                mem_w_mask = size_to_mask(size_e'(d_size));
            end
        end

        // Read data is the pre-write contents; memory commits the store at the same edge.
        last_grant_d   = grant_if ? GNT_IF : (grant_d ? GNT_D : NONE);
        if_resp_data_d = grant_if ? mem_read_data : if_resp_data_q;
        d_resp_data_d  = grant_d ? (d_we ? '0 : mem_read_data) : d_resp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q   <= NONE;
            if_resp_data_q <= '0;
            d_resp_data_q  <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            if_resp_data_q <= if_resp_data_d;
            d_resp_data_q  <= d_resp_data_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign d_req_ready   = grant_d;
    assign if_resp_valid = (last_grant_q == GNT_IF);
    assign d_resp_valid  = (last_grant_q == GNT_D);
    assign if_resp_data  = if_resp_data_q;
    assign d_resp_data   = d_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory, per-cycle reference model and
// directed plus random stimulus.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [15:0] if_addr;
    logic        if_flush;
    logic        if_resp_valid;
    logic [63:0] if_resp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [15:0] d_addr;
    logic        d_we;
    logic [1:0]  d_size;
    logic [63:0] d_wdata;
    logic        d_resp_valid;
    logic [63:0] d_resp_data;
    logic [7:0]  mem_w_mask;
    logic [15:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_resp_valid  (if_resp_valid),
        .if_resp_data   (if_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_ready    (d_req_ready),
        .d_addr         (d_addr),
        .d_we           (d_we),
        .d_size         (d_size),
        .d_wdata        (d_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .mem_w_mask     (mem_w_mask),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory driven by the DUT's memory port
    logic [7:0] env_mem [65536];
    // Independent golden memory updated only by the model
    logic [7:0] ref_mem [65536];

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            mem_read_data[8*i +: 8] = env_mem[16'(mem_address + 16'(i))];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (mem_w_mask[i]) env_mem[16'(mem_address + 16'(i))] <= mem_write_data[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model state
    int          m_refused = 0;
    logic        m_pend_if = 1'b0;
    logic        m_pend_d  = 1'b0;
    logic [63:0] m_if_data = '0;
    logic [63:0] m_d_data  = '0;

    always @(negedge clk) begin
        logic        e_if, e_d, ovr;
        logic [15:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata, rd;
        int          nbytes;

        ovr  = (m_refused >= LIMIT) && if_req_valid && !if_flush;
        e_if = !rst && if_req_valid && !if_flush && (!d_req_valid || ovr);
        e_d  = !rst && d_req_valid && !e_if;
        e_addr  = e_if ? if_addr : (e_d ? d_addr : 16'h0000);
        e_wdata = e_d ? d_wdata : 64'h0;
        nbytes  = 1 << d_size;
        e_mask  = (e_d && d_we) ? 8'((1 << nbytes) - 1) : 8'h00;

        chk("if_req_ready", 64'(if_req_ready), 64'(e_if));
        chk("d_req_ready", 64'(d_req_ready), 64'(e_d));
        chk("mem_w_mask", 64'(mem_w_mask), 64'(e_mask));
        if (!rst) begin
            chk("mem_address", 64'(mem_address), 64'(e_addr));
            chk("mem_write_data", mem_write_data, e_wdata);
        end
        chk("if_resp_valid", 64'(if_resp_valid), 64'(m_pend_if));
        chk("d_resp_valid", 64'(d_resp_valid), 64'(m_pend_d));
        if (m_pend_if) chk("if_resp_data", if_resp_data, m_if_data);
        if (m_pend_d)  chk("d_resp_data", d_resp_data, m_d_data);

        rd = '0;
        for (int i = 0; i < 8; i++) rd[8*i +: 8] = ref_mem[16'(e_addr + 16'(i))];
        if (rst) begin
            m_pend_if = 1'b0;
            m_pend_d  = 1'b0;
            m_if_data = '0;
            m_d_data  = '0;
            m_refused = 0;
        end else begin
            m_pend_if = e_if;
            m_pend_d  = e_d;
            if (e_if) m_if_data = rd;
            if (e_d)  m_d_data  = d_we ? 64'h0 : rd;
            for (int i = 0; i < 8; i++) begin
                if (e_mask[i]) ref_mem[16'(e_addr + 16'(i))] = e_wdata[8*i +: 8];
            end
            if (if_req_valid && !e_if && !if_flush)
                m_refused = (m_refused + 1 > LIMIT) ? LIMIT : m_refused + 1;
            else
                m_refused = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req_valid = 1'b0; if_flush = 1'b0; if_addr = '0;
        d_req_valid = 1'b0; d_we = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic d_req(input logic we, input logic [1:0] sz, input logic [15:0] a, input logic [63:0] wd);
        d_req_valid = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        logic [63:0] pat;
        for (int i = 0; i < 65536; i++) begin
            pat[7:0] = 8'($urandom);
            env_mem[i] = pat[7:0];
            ref_mem[i] = pat[7:0];
        end
        idle();
        rst = 1'b1;
        if_req_valid = 1'b1;
        d_req_valid  = 1'b1;
        @(negedge clk);
        chk("rst_if_ready", 64'(if_req_ready), 64'h0);
        chk("rst_d_ready", 64'(d_req_ready), 64'h0);
        chk("rst_mask", 64'(mem_w_mask), 64'h0);
        step();
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("post_rst_if_valid", 64'(if_resp_valid), 64'h0);
        chk("post_rst_d_valid", 64'(d_resp_valid), 64'h0);
        chk("post_rst_d_data", d_resp_data, 64'h0);
        step();

        // Store a doubleword, then load it back
        d_req(1'b1, 2'd3, 16'h0100, 64'h1122334455667788);
        @(negedge clk);
        chk("st_d_mask", 64'(mem_w_mask), 64'hFF);
        step();
        d_req(1'b0, 2'd3, 16'h0100, 64'h0);
        @(negedge clk);
        chk("st_resp_zero", d_resp_data, 64'h0);
        step();
        idle();
        @(negedge clk);
        chk("ld_resp_valid", 64'(d_resp_valid), 64'h1);
        chk("ld_resp_data", d_resp_data, 64'h1122334455667788);
        step();

        // Partial-width stores with a reload after each
        for (int s = 0; s < 3; s++) begin
            d_req(1'b1, 2'(s), 16'h0200, 64'hAABBCCDDEEFF0011);
            @(negedge clk);
            chk("size_mask", 64'(mem_w_mask), 64'((1 << (1 << s)) - 1));
            step();
            d_req(1'b0, 2'd3, 16'h0200, 64'h0);
            step();
            idle();
            @(negedge clk);
            chk("size_reload_low", d_resp_data & 64'h00000000000000FF, 64'h11);
            step();
        end

        // Continuous contention: IF wins every fifth cycle
        if_req_valid = 1'b1; if_addr = 16'h0100;
        d_req(1'b0, 2'd3, 16'h0200, 64'h0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("starve_pattern", 64'(if_req_ready), 64'((k % 5) == 4));
            step();
        end
        idle();
        step();

        // Flush blocks the fetch; starvation streak does not build
        if_req_valid = 1'b1; if_flush = 1'b1; if_addr = 16'h0040;
        @(negedge clk);
        chk("flush_ready", 64'(if_req_ready), 64'h0);
        step();
        if_flush = 1'b0;
        d_req(1'b0, 2'd3, 16'h0300, 64'h0);
        @(negedge clk);
        chk("flush_no_resp", 64'(if_resp_valid), 64'h0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("flush_then_contend", 64'(if_req_ready), 64'(k == 4));
            step();
        end
        idle();
        step();

        // Wrap-around doubleword store, then fetch the same address
        d_req(1'b1, 2'd3, 16'hFFFC, 64'h0102030405060708);
        step();
        idle();
        if_req_valid = 1'b1; if_addr = 16'hFFFC;
        step();
        idle();
        @(negedge clk);
        chk("wrap_byte_fffc", 64'(env_mem[16'hFFFC]), 64'h08);
        chk("wrap_byte_0003", 64'(env_mem[16'h0003]), 64'h01);
        chk("wrap_fetch_valid", 64'(if_resp_valid), 64'h1);
        chk("wrap_fetch_data", if_resp_data, 64'h0102030405060708);
        step();

        // Random traffic concentrated on a small window to exercise read-after-write
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            if_req_valid = 1'($urandom_range(0, 1));
            if_flush     = ($urandom_range(0, 4) == 0);
            if_addr      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'hFFF0, 16'hFFFF));
            d_req_valid  = ($urandom_range(0, 3) != 0);
            d_we         = 1'($urandom_range(0, 1));
            d_size       = 2'($urandom_range(0, 3));
            d_addr       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(16'hFFF0, 16'hFFFF));
            d_wdata      = {32'($urandom), 32'($urandom)};
            step();
        end
        rst = 1'b0;
        idle();
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
